// File: rtl/mem_host_pkg.sv
// Shared definitions for the host cache-line interface: line width, request
// opcodes and the responder state encoding.
package mem_host_pkg;

  localparam int LINE_W = 512;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RSVD = 2'b11
  } host_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10,
    HOLD = 2'b11
  } resp_state_e;

endpackage

// File: rtl/mem_line_store.sv
// DEPTH x LINE_W line array, one access per clock: synchronous write,
// combinational read of the addressed line. Contents are never reset.
module mem_line_store
  import mem_host_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_host_responder.sv
// Memory-side responder for the host cache-line interface: one line request at
// a time, completed after LATENCY wait cycles. Optional MEM_RESP_STATS_EN adds
// read/write completion counters.
//
//   state | meaning
//   IDLE  | ready; sample op_host each edge
//   WAIT  | latency countdown on latched request
//   RESP  | one-cycle completion pulse (store written / read data loaded)
//   HOLD  | one cycle ignoring op_host so a held request can be dropped
module mem_host_responder
  import mem_host_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op_host,
  input  logic [31:0]       AddrOut_host,
  input  logic [LINE_W-1:0] DataOut_host,
  output logic [LINE_W-1:0] DataIn_host,
  output logic              rd_valid_host,
  output logic              tx_done_host,
  output logic              busy,
  output logic              err
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  resp_state_e       r_state;
  host_op_e          r_op;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic [7:0]        r_cnt;
  logic [LINE_W-1:0] r_data_in;
  logic              r_rd_valid;
  logic              r_tx_done;
  logic              r_busy;
  logic              r_err;

  host_op_e          w_op;
  logic              w_enter_resp;
  logic              w_store_we;
  logic [LINE_W-1:0] w_store_rdata;
  logic              w_unused_addr;

  assign w_op          = host_op_e'(op_host);
  assign w_enter_resp  = (r_state == WAIT) && (r_cnt == 8'd0);
  assign w_store_we    = w_enter_resp && (r_op == OP_WR);
  // Only the line index is decoded; offset and high bits are dropped silently.
  assign w_unused_addr = ^{AddrOut_host[31:6+IDX_W], AddrOut_host[5:0]};

  mem_line_store #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_store (
    .clk     (clk),
    .i_we    (w_store_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_store_rdata)
  );

`ifdef MEM_RESP_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_IDLE;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_cnt      <= 8'd0;
      r_data_in  <= '0;
      r_rd_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
`ifdef MEM_RESP_STATS_EN
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((w_op == OP_RD) || (w_op == OP_WR)) begin
            r_op    <= w_op;
            r_idx   <= AddrOut_host[6 +: IDX_W];
            r_wdata <= DataOut_host;
            r_cnt   <= 8'(LATENCY - 1);
            r_state <= WAIT;
            r_busy  <= 1'b1;
          end else if (w_op == OP_RSVD) begin
            r_err <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state   <= RESP;
            r_tx_done <= 1'b1;
            if (r_op == OP_RD) begin
              r_rd_valid <= 1'b1;
              r_data_in  <= w_store_rdata;
            end
`ifdef MEM_RESP_STATS_EN
            if (r_op == OP_RD) begin
              r_rd_count <= r_rd_count + 32'd1;
            end else begin
              r_wr_count <= r_wr_count + 32'd1;
            end
`endif
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP: begin
          r_state <= HOLD;
        end
        HOLD: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DataIn_host   = r_data_in;
  assign rd_valid_host = r_rd_valid;
  assign tx_done_host  = r_tx_done;
  assign busy          = r_busy;
  assign err           = r_err;

endmodule
